// File: rtl/seq_pkg.sv
// Types and helpers shared by the serial pattern detector and its testbench.
// Holds the FSM state encoding and the pattern-length validity rule.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // A configured length is usable when it selects between 1 and max_len bits.
    function automatic logic len_valid(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear.
// A clear coinciding with an increment leaves the counter at 1.
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Configurable serial sequence detector with overlap control.
// Pattern, length and overlap are held in shadow registers loaded by cfg_load.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed,
    output logic               cfg_err
);

    state_t             state;
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] pattern_sh;
    logic [LEN_W-1:0]   len_sh;
    logic               overlap_sh;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               sample;
    logic               match;
    logic               cfg_ok;

    // Only the low len_sh bits of history and pattern take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_sh);
        end
    endgenerate

    always_comb begin
        hist_shift = {history[MAX_LEN-2:0], in};
        fill_inc   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        // A configuration strobe takes priority over a data bit on the same edge.
        sample     = (state == ST_ARMED) && in_valid && !cfg_load;
        match      = sample && (fill_inc >= len_sh)
                     && (((hist_shift ^ pattern_sh) & len_mask) == '0);
        cfg_ok     = len_valid(int'(pat_len), MAX_LEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            history    <= '0;
            pattern_sh <= '0;
            len_sh     <= '0;
            overlap_sh <= 1'b0;
            fill       <= '0;
            out        <= 1'b0;
            armed      <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            out <= match;
            if (cfg_load) begin
                pattern_sh <= pattern;
                len_sh     <= pat_len;
                overlap_sh <= overlap;
                history    <= '0;
                fill       <= '0;
                state      <= cfg_ok ? ST_ARMED : ST_ERR;
                armed      <= cfg_ok;
                cfg_err    <= !cfg_ok;
            end else if (sample) begin
                history <= hist_shift;
                // Non-overlapping mode restarts the fill so no bit is reused.
                fill    <= (match && !overlap_sh) ? '0 : fill_inc;
            end
        end
    end

    seq_match_cnt #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomized and directed bench for seq_detect_param against a queue-based model.
// Two instances share stimulus: default widths and a 2-bit match counter.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_in = 1'b0;
    logic       d_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pat_len = '0;
    logic       overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       out_a, armed_a, err_a;
    logic [7:0] cnt_a;
    logic       out_b, armed_b, err_b;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    // Reference model state
    int       m_state;          // 0 idle, 1 armed, 2 error
    logic [7:0] m_pattern;
    int       m_len;
    bit       m_ovl;
    bit       hist_q[$];
    int       cnt8, cnt2;
    bit       exp_out;

    always #5 clk = ~clk;

    seq_detect_param dut_a (
        .clk(clk), .rst(rst), .in(d_in), .in_valid(d_valid), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .out(out_a), .match_cnt(cnt_a), .armed(armed_a), .cfg_err(err_a)
    );

    seq_detect_param #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in(d_in), .in_valid(d_valid), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .out(out_b), .match_cnt(cnt_b), .armed(armed_b), .cfg_err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pattern = '0; m_len = 0; m_ovl = 0;
        hist_q.delete(); cnt8 = 0; cnt2 = 0; exp_out = 0;
    endtask

    // Evaluate the rules for the inputs currently driven, as of the next edge.
    task automatic model_step();
        bit match;
        match = 0;
        if (cfg_load) begin
            m_pattern = pattern; m_len = int'(pat_len); m_ovl = overlap;
            hist_q.delete();
            m_state = (m_len >= 1 && m_len <= 8) ? 1 : 2;
        end else if (m_state == 1 && d_valid) begin
            hist_q.push_back(d_in);
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            if (hist_q.size() >= m_len) begin
                match = 1;
                for (int k = 0; k < m_len; k++)
                    if (hist_q[hist_q.size()-1-k] != m_pattern[k]) match = 0;
            end
            if (match && !m_ovl) hist_q.delete();
        end
        exp_out = match;
        if (cnt_clr) begin
            cnt8 = match ? 1 : 0;
            cnt2 = match ? 1 : 0;
        end else if (match) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3) cnt2++;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".out"}, 32'(out_a), 32'(exp_out));
        check_eq({tag, ".cnt"}, 32'(cnt_a), 32'(cnt8));
        check_eq({tag, ".cnt2"}, 32'(cnt_b), 32'(cnt2));
        check_eq({tag, ".armed"}, 32'(armed_a), 32'(m_state == 1));
        check_eq({tag, ".cfg_err"}, 32'(err_a), 32'(m_state == 2));
        check_eq({tag, ".out_b"}, 32'(out_b), 32'(exp_out));
        check_eq({tag, ".armed_b"}, 32'(armed_b), 32'(m_state == 1));
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1;
        compare_all("cyc");
        n_pulses += int'(out_a);
    endtask

    task automatic send_bit(input bit b);
        d_in = b; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        pattern = pat; pat_len = len; overlap = ovl; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        pattern = 8'($urandom); pat_len = 4'($urandom); overlap = 1'($urandom);
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all("rst0");
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // Test 1: overlapping detection of 1010101
        do_cfg(8'b0101_0101, 4'd7, 1'b1);
        n_pulses = 0;
        send_stream(16'b1_0101_0101_0101, 13);
        step();
        check_eq("t1.pulses", 32'(n_pulses), 32'd4);
        check_eq("t1.cnt", 32'(cnt_a), 32'd4);
        $display("test1 overlap: pulses=%0d cnt=%0d", n_pulses, cnt_a);

        // Test 2: same stream, non-overlapping
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        do_cfg(8'b1101_0101, 4'd7, 1'b0);
        n_pulses = 0;
        send_stream(16'b1_0101_0101_0101, 13);
        step();
        check_eq("t2.pulses", 32'(n_pulses), 32'd1);
        check_eq("t2.cnt", 32'(cnt_a), 32'd1);
        $display("test2 no-overlap: pulses=%0d cnt=%0d", n_pulses, cnt_a);

        // Test 3: invalid lengths then recovery
        n_pulses = 0;
        do_cfg(8'h00, 4'd0, 1'b1);
        check_eq("t3.err0", 32'(err_a), 32'd1);
        send_stream(16'h0000, 8);
        do_cfg(8'hff, 4'd9, 1'b1);
        check_eq("t3.err9", 32'(err_a), 32'd1);
        send_stream(16'hffff, 10);
        check_eq("t3.pulses", 32'(n_pulses), 32'd0);
        do_cfg(8'b0000_0011, 4'd2, 1'b1);
        check_eq("t3.armed", 32'(armed_a), 32'd1);
        check_eq("t3.noerr", 32'(err_a), 32'd0);
        $display("test3 cfg errors: pulses=%0d armed=%0d", n_pulses, armed_a);

        // Test 4: 1011 with random gaps between valid bits
        do_cfg(8'b1111_1011, 4'd4, 1'b1);
        n_pulses = 0;
        begin
            logic [3:0] p4;
            p4 = 4'b1011;
            for (int i = 3; i >= 0; i--) begin
                idle(int'($urandom_range(0, 3)));
                send_bit(p4[i]);
            end
        end
        check_eq("t4.out", 32'(out_a), 32'd1);
        idle(3);
        check_eq("t4.pulses", 32'(n_pulses), 32'd1);
        $display("test4 gaps: pulses=%0d", n_pulses);

        // Test 5: saturation of the 2-bit counter and clear-with-match
        do_cfg(8'b0000_0001, 4'd1, 1'b1);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        send_stream(16'h001f, 5);
        check_eq("t5.sat2", 32'(cnt_b), 32'd3);
        check_eq("t5.cnt8", 32'(cnt_a), 32'd5);
        cnt_clr = 1'b1; send_bit(1'b1); cnt_clr = 1'b0;
        check_eq("t5.clrmatch", 32'(cnt_b), 32'd1);
        $display("test5 saturate: cnt2=%0d cnt8=%0d", cnt_b, cnt_a);

        // Test 6: reset mid-sequence discards the partial match
        do_cfg(8'b0101_0101, 4'd7, 1'b1);
        n_pulses = 0;
        send_stream(16'b10_1010, 6);
        do_reset();
        do_cfg(8'b0101_0101, 4'd7, 1'b1);
        send_bit(1'b1);
        idle(2);
        check_eq("t6.nopulse", 32'(n_pulses), 32'd0);
        send_stream(16'b101_0101, 7);
        step();
        check_eq("t6.pulse", 32'(n_pulses), 32'd1);
        $display("test6 reset: pulses=%0d", n_pulses);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                do_reset();
            end else begin
                d_in     = 1'($urandom);
                d_valid  = ($urandom_range(0, 9) < 7);
                cnt_clr  = ($urandom_range(0, 99) < 3);
                cfg_load = ($urandom_range(0, 99) < 3) || (m_state == 0);
                pattern  = 8'($urandom);
                overlap  = 1'($urandom);
                if ($urandom_range(0, 9) == 0) pat_len = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(9, 15));
                else if ($urandom_range(0, 3) == 0) pat_len = 4'($urandom_range(5, 8));
                else pat_len = 4'($urandom_range(1, 4));
                step();
                cfg_load = 1'b0; cnt_clr = 1'b0; d_valid = 1'b0;
            end
        end
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1), width of the pattern-length field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low (0 = reset).
REQ-006 in  input  1  serial data bit.
REQ-007 in_valid  input  1  in is sampled only when 1.
REQ-008 cfg_load  input  1  one-cycle strobe that latches pattern, pat_len and overlap.
REQ-009 pattern  input  MAX_LEN  target sequence; first-received bit is pattern[pat_len-1], last is pattern[0].
REQ-010 pat_len  input  LEN_W  active pattern length.
REQ-011 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-013 out  output  1  registered one-cycle match pulse.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 armed  output  1  high while in ARMED state.
REQ-016 cfg_err  output  1  high while in ERR state.

Function
REQ-017 The FSM SHALL have three states: IDLE, ARMED and ERR.
REQ-018 IDLE: out=0; no detection; cfg_load moves to ARMED if 1 <= pat_len <= MAX_LEN, else to ERR.
REQ-019 ARMED and ERR: cfg_load SHALL re-evaluate pat_len with the same rule; ERR SHALL ignore in_valid.
REQ-020 cfg_load SHALL latch pattern, pat_len and overlap into shadow registers, and SHALL clear the history and fill count on the same edge.
REQ-021 Inputs pattern, pat_len and overlap SHALL affect behaviour only through the shadow registers.
REQ-022 Per ARMED edge with in_valid=1: shift in into the history LSB; fill = min(fill+1, MAX_LEN).
REQ-023 Match condition: new fill >= shadow pat_len and the low pat_len bits of the new history equal the low pat_len bits of the shadow pattern.
REQ-024 On a match, out SHALL be 1 for exactly the next cycle.
REQ-025 Latency: 1 cycle from the edge that samples the final pattern bit to the out pulse.
REQ-026 overlap=1: history and fill SHALL be retained after a match.
REQ-027 overlap=0: fill SHALL be cleared on the matching edge, so no bit can contribute to two matches.
REQ-028 Cycles with in_valid=0 SHALL leave the history, fill and out=0 unchanged; gaps do not break a sequence.
REQ-029 match_cnt SHALL increment on each match and saturate at 2^CNT_W-1.
REQ-030 cnt_clr SHALL set match_cnt to 0; if cnt_clr coincides with a match, match_cnt SHALL become 1.
REQ-031 If cfg_load coincides with in_valid, cfg_load SHALL win: the bit is discarded and no match is evaluated on that edge.
REQ-032 Bits of pattern above pat_len-1 SHALL be ignored.

Reset
REQ-033 rst=0 SHALL asynchronously set: state=IDLE, history=0, fill=0, out=0, match_cnt=0, armed=0, cfg_err=0, shadow registers=0.
REQ-034 Reset asserted mid-sequence SHALL discard any partial match; after release, a cfg_load is required before detection resumes.

Structure
REQ-035 The state encoding (IDLE/ARMED/ERR) and the length-validity function SHALL live in the shared package seq_pkg.
REQ-036 One sub-module, seq_match_cnt, SHALL implement the saturating counter with clear; the rest of the design is flat.

Verification
REQ-037 Test 1: MAX_LEN=8; cfg pattern=7'b1010101, len=7, overlap=1; stream 1010101010101 -> out pulses after bits 7, 9, 11 and 13; match_cnt=4.
REQ-038 Test 2: same stream with overlap=0 -> a single pulse after bit 7; match_cnt=1.
REQ-039 Test 3: pat_len=0 and pat_len=9 -> cfg_err=1 and no pulses; a following valid cfg -> armed=1 and cfg_err=0.
REQ-040 Test 4: pattern 1011 with in_valid=0 gaps of 0-3 cycles between bits -> one pulse, 1 cycle after the final valid bit.
REQ-041 Test 5: CNT_W=2 with 5 matches -> match_cnt=3; cnt_clr on the same edge as a match -> match_cnt=1.
REQ-042 Test 6: rst=0 after 6 of 7 pattern bits, then release and re-cfg, then 1 more bit -> no pulse; full pattern -> pulse.
